fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter HALT_WORD, default 9'h1FF, the instruction word that stops fetching.
REQ-002 SHALL have parameter LUT_DEPTH, default 32, the number of branch-target LUT entries (used only with FETCH_BRANCH_LUT_EN).
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  begin fetching from address 0; a pulse is sufficient.
REQ-006 stall  in  1  downstream cannot accept the current instruction.
REQ-007 branch_taken  in  1  redirect fetch; sampled only when instr_valid=1 and stall=0.
REQ-008 branch_idx  in  5  branch selector: LUT index or signed offset.
REQ-009 instruct  in  9  instruction-memory data; registered, one-cycle latency from addr.
REQ-010 addr  out  8  registered instruction-memory address.
REQ-011 instr_out  out  9  instruction to the decoder.
REQ-012 pc_out  out  8  address of instr_out.
REQ-013 instr_valid  out  1  instr_out/pc_out are valid, non-squashed.
REQ-014 done  out  1  HALT_WORD has been consumed.

Function
REQ-015 SHALL implement states IDLE, RUN and HALT.
REQ-016 IDLE: addr=0, instr_valid=0; start=1 -> RUN, with addr<=1, pc_out<=0, instr_valid<=1 at the same edge.
REQ-017 RUN, stall=0, no branch: addr<=addr+1 (255 wraps to 0), pc_out<=addr, instr_valid<=1.
REQ-018 stall=1 in RUN: addr, pc_out and instr_valid hold.
REQ-019 First stalled edge: capture instruct into a skid register and set hold_flag.
REQ-020 instr_out = skid register when hold_flag=1, else instruct.
REQ-021 hold_flag clears on the first edge with stall=0.
REQ-022 instr_out and pc_out SHALL stay constant for the entire stall.
REQ-023 branch_taken=1 with instr_valid=1 and stall=0: addr<=target, instr_valid<=0 next cycle (the one wrong-path slot is squashed).
REQ-024 Following a branch, the next edge gives pc_out=target and instr_valid=1; the penalty is exactly 1 bubble.
REQ-025 branch_taken with stall=1 or instr_valid=0 SHALL be ignored.
REQ-026 instr_valid=1, stall=0, instr_out==HALT_WORD: -> HALT with done<=1, instr_valid<=0 and addr held.
REQ-027 HALT takes priority over a simultaneous branch_taken.
REQ-028 HALT: done stays 1; start=1 -> RUN from address 0 as in REQ-016, with done<=0.
REQ-029 start in RUN SHALL be ignored.

Reset
REQ-030 reset=1 SHALL immediately force: state IDLE, addr=0, pc_out=0, instr_valid=0, done=0, hold_flag=0, skid register 0.
REQ-031 Reset mid-stall or mid-branch SHALL discard all pending state.
REQ-032 Reset SHALL NOT clear the branch-target LUT contents.

Configuration
REQ-033 Macro FETCH_BRANCH_LUT_EN defined: target = lut[branch_idx], an 8-bit x LUT_DEPTH table.
REQ-034 With FETCH_BRANCH_LUT_EN, the table is written via extra inputs lut_we (1), lut_waddr (5), lut_wdata (8), synchronously.
REQ-035 With FETCH_BRANCH_LUT_EN, a same-cycle write and branch to the same index SHALL use the old entry.
REQ-036 Macro undefined: no LUT ports; target = pc_out + sign-extended branch_idx, modulo 256.

Verification
REQ-037 reset, then start pulse, memory mem[i]=i, no stall -> pc_out 0,1,2,3 on consecutive cycles, instr_valid=1 from the cycle after start.
REQ-038 stall high 3 cycles while pc_out=2 -> instr_out=mem[2] and pc_out=2 held for 3 cycles, then pc_out=3 with instr_out=mem[3].
REQ-039 branch_taken at pc_out=4: relative mode branch_idx=5'b11110 -> one cycle instr_valid=0, then pc_out=2; LUT mode lut[3]=8'h40, branch_idx=3 -> bubble, then pc_out=8'h40.
REQ-040 mem[5]=9'h1FF -> done=1 one cycle after pc_out=5; addr frozen; instr_valid=0; start again -> pc_out=0.
REQ-041 run to pc_out=255 -> next pc_out=0; reset asserted mid-stall -> all outputs 0 asynchronously; state IDLE.

Source files
------------

// File: rtl/fetch_ctrl.sv
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Instruction fetch controller. It sequences the instruction-memory
//             address, adds a skid register so a stalled instruction stays
//             stable, redirects fetch on a taken branch with one squashed
//             slot, and stops when the halt word is consumed.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1  clock, rising edge
//    reset        in   1  asynchronous, active-high reset
//    start        in   1  begin fetching at address 0 (pulse)
//    stall        in   1  downstream cannot accept the current instruction
//    branch_taken in   1  redirect fetch (used when instr_valid=1, stall=0)
//    branch_idx   in   5  LUT index or signed 5-bit offset
//    instruct     in   9  instruction memory data (one-cycle latency)
//    addr         out  8  instruction memory address
//    instr_out    out  9  instruction to the decoder
//    pc_out       out  8  address of instr_out
//    instr_valid  out  1  instr_out/pc_out valid and not squashed
//    done         out  1  halt word has been consumed
//  Build option
//    FETCH_BRANCH_LUT_EN : branch target comes from an 8-bit x LUT_DEPTH
//                          table written through lut_we/lut_waddr/lut_wdata.
//                          When undefined, target = pc_out + sext(branch_idx).
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter logic [8:0] HALT_WORD = 9'h1FF,
  parameter int         LUT_DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [4:0] branch_idx,
  input  logic [8:0] instruct,
`ifdef FETCH_BRANCH_LUT_EN
  input  logic       lut_we,
  input  logic [4:0] lut_waddr,
  input  logic [7:0] lut_wdata,
`endif
  output logic [7:0] addr,
  output logic [8:0] instr_out,
  output logic [7:0] pc_out,
  output logic       instr_valid,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] addr_next, pc_next, target;
  logic [8:0] skid, skid_next;
  logic       valid_next, done_next, hold_flag, hold_next;

  // ------------------------------------------------------------------
  // Branch target
  // ------------------------------------------------------------------
`ifdef FETCH_BRANCH_LUT_EN
  // Table is intentionally not reset so its contents survive reset.
  // A same-cycle write is only visible after the edge, so a branch to
  // the index being written sees the old entry.
  logic [7:0] lut [LUT_DEPTH];

  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  assign target = lut[branch_idx];
`else
  logic [31:0] unused_lut_depth;
  assign unused_lut_depth = LUT_DEPTH;

  assign target = pc_out + {{3{branch_idx[4]}}, branch_idx};
`endif

  // While stalled the memory already shows the word at addr (the next
  // instruction), so the stalled instruction is replayed from the skid.
  assign instr_out = hold_flag ? skid : instruct;

  // ------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= 8'd0;
      pc_out      <= 8'd0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      hold_flag   <= 1'b0;
      skid        <= 9'd0;
    end else begin
      state       <= state_next;
      addr        <= addr_next;
      pc_out      <= pc_next;
      instr_valid <= valid_next;
      done        <= done_next;
      hold_flag   <= hold_next;
      skid        <= skid_next;
    end
  end

  // ------------------------------------------------------------------
  // Next-state and next-value logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    addr_next  = addr;
    pc_next    = pc_out;
    valid_next = instr_valid;
    done_next  = done;
    hold_next  = hold_flag;
    skid_next  = skid;

    case (state)
      IDLE: begin
        addr_next  = 8'd0;
        valid_next = 1'b0;
        hold_next  = 1'b0;
        if (start) begin
          state_next = RUN;
          addr_next  = 8'd1;
          pc_next    = 8'd0;
          valid_next = 1'b1;
        end
      end

      RUN: begin
        if (stall) begin
          // Capture only on the first stalled edge; later edges would
          // overwrite it with the next instruction.
          if (!hold_flag) begin
            skid_next = instruct;
            hold_next = 1'b1;
          end
        end else begin
          hold_next = 1'b0;
          if (instr_valid && (instr_out == HALT_WORD)) begin
            // Halt wins over a simultaneous branch; addr is frozen.
            state_next = HALT;
            done_next  = 1'b1;
            valid_next = 1'b0;
          end else if (instr_valid && branch_taken) begin
            // The word fetched at this edge is wrong-path; squash it.
            addr_next  = target;
            valid_next = 1'b0;
          end else begin
            addr_next  = addr + 8'd1;
            pc_next    = addr;
            valid_next = 1'b1;
          end
        end
      end

      HALT: begin
        hold_next = 1'b0;
        if (start) begin
          state_next = RUN;
          addr_next  = 8'd1;
          pc_next    = 8'd0;
          valid_next = 1'b1;
          done_next  = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Purpose  : Directed self-checking bench for fetch_ctrl with a registered
//             instruction memory model (one-cycle latency, output cleared by
//             reset).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stall;
  logic       branch_taken;
  logic [4:0] branch_idx;
  logic [8:0] instruct;
  logic [7:0] addr;
  logic [8:0] instr_out;
  logic [7:0] pc_out;
  logic       instr_valid;
  logic       done;
`ifdef FETCH_BRANCH_LUT_EN
  logic       lut_we;
  logic [4:0] lut_waddr;
  logic [7:0] lut_wdata;
`endif

  logic [8:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_idx   (branch_idx),
    .instruct     (instruct),
`ifdef FETCH_BRANCH_LUT_EN
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
`endif
    .addr         (addr),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered instruction memory.
  always @(posedge clk or posedge reset) begin
    if (reset) instruct <= 9'd0;
    else       instruct <= mem[addr];
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'(i);
    reset        = 1'b1;
    start        = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_idx   = 5'd0;
`ifdef FETCH_BRANCH_LUT_EN
    lut_we    = 1'b0;
    lut_waddr = 5'd0;
    lut_wdata = 8'd0;
`endif

    // Reset state
    #12;
    chk("rst_addr",  9'(addr),        9'd0);
    chk("rst_pc",    9'(pc_out),      9'd0);
    chk("rst_valid", 9'(instr_valid), 9'd0);
    chk("rst_done",  9'(done),        9'd0);
    reset = 1'b0;
    tick;
    chk("idle_addr",  9'(addr),        9'd0);
    chk("idle_valid", 9'(instr_valid), 9'd0);

    // Start pulse and sequential fetch
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("s0_pc",    9'(pc_out),      9'd0);
    chk("s0_valid", 9'(instr_valid), 9'd1);
    chk("s0_addr",  9'(addr),        9'd1);
    chk("s0_instr", instr_out,       9'd0);
    tick;
    chk("s1_pc",    9'(pc_out), 9'd1);
    chk("s1_instr", instr_out,  9'd1);
    tick;
    chk("s2_pc",    9'(pc_out), 9'd2);
    chk("s2_instr", instr_out,  9'd2);

    // Stall for three cycles at pc 2
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("stall_pc",    9'(pc_out),      9'd2);
      chk("stall_instr", instr_out,       9'd2);
      chk("stall_valid", 9'(instr_valid), 9'd1);
      chk("stall_addr",  9'(addr),        9'd3);
    end
    stall = 1'b0;
    tick;
    chk("unstall_pc",    9'(pc_out), 9'd3);
    chk("unstall_instr", instr_out,  9'd3);
    tick;
    chk("s4_pc", 9'(pc_out), 9'd4);

    // Backward relative branch at pc 4 (offset -2)
    branch_taken = 1'b1;
    branch_idx   = 5'b11110;
    tick;
    branch_taken = 1'b0;
    chk("br_bubble", 9'(instr_valid), 9'd0);
    chk("br_addr",   9'(addr),        9'd2);
    mem[5] = 9'h1FF;
    tick;
    chk("br_pc",    9'(pc_out),      9'd2);
    chk("br_valid", 9'(instr_valid), 9'd1);
    chk("br_instr", instr_out,       9'd2);

    // Branch ignored while stalled
    stall        = 1'b1;
    branch_taken = 1'b1;
    tick;
    chk("brst_pc",    9'(pc_out),      9'd2);
    chk("brst_addr",  9'(addr),        9'd3);
    chk("brst_valid", 9'(instr_valid), 9'd1);
    stall        = 1'b0;
    branch_taken = 1'b0;
    tick;
    chk("brst_next", 9'(pc_out), 9'd3);

    // Forward branch +2 at pc 3, then branch during the bubble is ignored
    branch_taken = 1'b1;
    branch_idx   = 5'd2;
    tick;
    chk("fwd_addr",  9'(addr),        9'd5);
    chk("fwd_valid", 9'(instr_valid), 9'd0);
    branch_idx = 5'd9;
    tick;
    chk("bub_pc",    9'(pc_out),      9'd5);
    chk("bub_addr",  9'(addr),        9'd6);
    chk("bub_instr", instr_out,       9'h1FF);

    // Halt word with simultaneous branch: halt wins
    tick;
    branch_taken = 1'b0;
    chk("halt_done",  9'(done),        9'd1);
    chk("halt_valid", 9'(instr_valid), 9'd0);
    chk("halt_addr",  9'(addr),        9'd6);
    tick;
    chk("halt_hold_done", 9'(done), 9'd1);
    chk("halt_hold_addr", 9'(addr), 9'd6);

    // Restart from halt
    mem[5] = 9'd5;
    start  = 1'b1;
    tick;
    chk("rs_pc",    9'(pc_out),      9'd0);
    chk("rs_valid", 9'(instr_valid), 9'd1);
    chk("rs_done",  9'(done),        9'd0);
    chk("rs_addr",  9'(addr),        9'd1);
    // start held in RUN is ignored
    tick;
    start = 1'b0;
    chk("run_start_pc",   9'(pc_out), 9'd1);
    chk("run_start_addr", 9'(addr),   9'd2);

    // Run up to pc 255 and wrap
    for (int k = 0; k < 254; k++) tick;
    chk("pc255",     9'(pc_out), 9'd255);
    chk("pc255_ins", instr_out,  9'd255);
    tick;
    chk("wrap_pc",   9'(pc_out), 9'd0);
    chk("wrap_ins",  instr_out,  9'd0);
    chk("wrap_addr", 9'(addr),   9'd1);

    // Relative branch wraps modulo 256: 0 + (-2) = 254
    branch_taken = 1'b1;
    branch_idx   = 5'b11110;
    tick;
    branch_taken = 1'b0;
    chk("brwrap_addr", 9'(addr), 9'd254);
    tick;
    chk("brwrap_pc", 9'(pc_out), 9'd254);

    // Asynchronous reset in the middle of a stall
    stall = 1'b1;
    tick;
    #3;
    reset = 1'b1;
    #1;
    chk("ar_addr",  9'(addr),           9'd0);
    chk("ar_pc",    9'(pc_out),         9'd0);
    chk("ar_valid", 9'(instr_valid),    9'd0);
    chk("ar_done",  9'(done),           9'd0);
    chk("ar_instr", instr_out,          9'd0);
    chk("ar_state", 9'(dut.state),      9'd0);
    chk("ar_hold",  9'(dut.hold_flag),  9'd0);
    stall = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    chk("post_idle", 9'(instr_valid), 9'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("post_pc",    9'(pc_out),      9'd0);
    chk("post_valid", 9'(instr_valid), 9'd1);
    tick;
    chk("post_pc1", 9'(pc_out), 9'd1);

`ifdef FETCH_BRANCH_LUT_EN
    // LUT target; same-cycle write to the branch index uses the old entry
    lut_we    = 1'b1;
    lut_waddr = 5'd3;
    lut_wdata = 8'h40;
    tick;
    lut_wdata    = 8'h80;
    branch_taken = 1'b1;
    branch_idx   = 5'd3;
    tick;
    lut_we       = 1'b0;
    branch_taken = 1'b0;
    chk("lut_bubble", 9'(instr_valid), 9'd0);
    chk("lut_addr",   9'(addr),        9'h40);
    tick;
    chk("lut_pc", 9'(pc_out), 9'h40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
